// File: rtl/cafeteira_pkg.sv
// Shared types for the coffee-maker control unit: FSM state codes and error causes.
package cafeteira_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    ESPERA_PEDIDO = 4'h1,
    MEDE_AGUA     = 4'h2,
    ESPERA_AGUA   = 4'h3,
    ZERA_AGUA     = 4'h4,
    CHECA_AGUA    = 4'h5,
    MEDE_XICARA   = 4'h6,
    ESPERA_XICARA = 4'h7,
    ZERA_XICARA   = 4'h8,
    CHECA_XICARA  = 4'h9,
    ESPERA_GAP    = 4'hA,
    BOMBA         = 4'hB,
    EBULIDOR      = 4'hC,
    VALVULA       = 4'hD,
    FIM           = 4'hE,
    ERRO          = 4'hF
  } estado_t;

  localparam logic [2:0] ERR_NENHUM           = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT_AGUA     = 3'd1;
  localparam logic [2:0] ERR_SEM_AGUA         = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT_XICARA   = 3'd3;
  localparam logic [2:0] ERR_SEM_XICARA       = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT_EBULIDOR = 3'd5;
  localparam logic [2:0] ERR_XICARA_REMOVIDA  = 3'd6;

endpackage

// File: rtl/cafeteira_uc_if.sv
// Control/status bundle between the coffee-maker control unit (master) and its datapath (slave).
interface cafeteira_uc_if;
  logic pronto_serial, pronto_sensor_agua, timeout_agua, suficiente;
  logic pronto_sensor_xicara, timeout_xicara, tem_xicara;
  logic fim_bomba, fim_ebulidor, timeout_ebulidor, fim_valvula;
  logic reconhece;
  logic zera_sensor_agua, zera_sensor_xicara, zera_bomba, zera_valvula, zera_ebulidor, zera_serial;
  logic medir_agua, verifica_xicara;
  logic liga_bomba, liga_ebulidor, liga_valvula;
  logic pronto, erro;
  logic [2:0] codigo_erro;
  logic [3:0] db_estado;

  modport master (
    input  pronto_serial, pronto_sensor_agua, timeout_agua, suficiente,
           pronto_sensor_xicara, timeout_xicara, tem_xicara,
           fim_bomba, fim_ebulidor, timeout_ebulidor, fim_valvula, reconhece,
    output zera_sensor_agua, zera_sensor_xicara, zera_bomba, zera_valvula, zera_ebulidor,
           zera_serial, medir_agua, verifica_xicara, liga_bomba, liga_ebulidor, liga_valvula,
           pronto, erro, codigo_erro, db_estado
  );

  modport slave (
    output pronto_serial, pronto_sensor_agua, timeout_agua, suficiente,
           pronto_sensor_xicara, timeout_xicara, tem_xicara,
           fim_bomba, fim_ebulidor, timeout_ebulidor, fim_valvula, reconhece,
    input  zera_sensor_agua, zera_sensor_xicara, zera_bomba, zera_valvula, zera_ebulidor,
           zera_serial, medir_agua, verifica_xicara, liga_bomba, liga_ebulidor, liga_valvula,
           pronto, erro, codigo_erro, db_estado
  );
endinterface

// File: rtl/cafeteira_uc_contador_gap.sv
// Clear/enable counter running 0..MODULO-1; fim flags the last count and the counter wraps to 0.
module contador_gap #(
  parameter int unsigned MODULO = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);
  localparam int unsigned W = $clog2(MODULO + 1);
  localparam logic [W-1:0] ULTIMO = W'(MODULO - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (zera)   cnt <= '0;
    else if (conta)  cnt <= fim ? '0 : cnt + 1'b1;
  end

  assign fim = (cnt == ULTIMO);
endmodule

// File: rtl/cafeteira_uc.sv
// Moore control unit sequencing one coffee brew order.
// Optional cup re-check after heating: define CAFETEIRA_RECHECA_XICARA_EN.
module cafeteira_uc
  import cafeteira_pkg::*;
#(
  parameter int unsigned MAX_TENTATIVAS    = 3,
  parameter int unsigned MAX_ESPERA_XICARA = 10,
  parameter int unsigned GAP_CICLOS        = 50000000
) (
  input  logic           clock,
  input  logic           reset,
  cafeteira_uc_if.master bus
);
  localparam int unsigned TW = $clog2(MAX_TENTATIVAS + 1);
  localparam int unsigned EW = $clog2(MAX_ESPERA_XICARA + 1);
  localparam logic [TW-1:0] TENT_LIM = TW'(MAX_TENTATIVAS - 1);
  localparam logic [EW-1:0] ESP_LIM  = EW'(MAX_ESPERA_XICARA - 1);

  estado_t       estado, estado_nxt;
  logic [TW-1:0] tentativas, tentativas_nxt;
  logic [EW-1:0] esperas, esperas_nxt;
  logic [2:0]    codigo, codigo_nxt;
  logic          gap_zera, gap_conta, gap_fim;
`ifdef CAFETEIRA_RECHECA_XICARA_EN
  logic          recheca, recheca_nxt;
`endif

  logic zera_sensor_agua, zera_sensor_xicara, zera_bomba, zera_valvula, zera_ebulidor, zera_serial;
  logic medir_agua, verifica_xicara, liga_bomba, liga_ebulidor, liga_valvula, pronto, erro;

  contador_gap #(.MODULO(GAP_CICLOS)) u_gap (
    .clock (clock),
    .reset (reset),
    .zera  (gap_zera),
    .conta (gap_conta),
    .fim   (gap_fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= INICIAL;
      tentativas <= '0;
      esperas    <= '0;
      codigo     <= ERR_NENHUM;
`ifdef CAFETEIRA_RECHECA_XICARA_EN
      recheca    <= 1'b0;
`endif
    end else begin
      estado     <= estado_nxt;
      tentativas <= tentativas_nxt;
      esperas    <= esperas_nxt;
      codigo     <= codigo_nxt;
`ifdef CAFETEIRA_RECHECA_XICARA_EN
      recheca    <= recheca_nxt;
`endif
    end
  end

  always_comb begin
    estado_nxt         = estado;
    tentativas_nxt     = tentativas;
    esperas_nxt        = esperas;
    codigo_nxt         = codigo;
`ifdef CAFETEIRA_RECHECA_XICARA_EN
    recheca_nxt        = recheca;
`endif
    gap_zera           = 1'b0;
    gap_conta          = 1'b0;
    zera_sensor_agua   = 1'b0;
    zera_sensor_xicara = 1'b0;
    zera_bomba         = 1'b0;
    zera_valvula       = 1'b0;
    zera_ebulidor      = 1'b0;
    zera_serial        = 1'b0;
    medir_agua         = 1'b0;
    verifica_xicara    = 1'b0;
    liga_bomba         = 1'b0;
    liga_ebulidor      = 1'b0;
    liga_valvula       = 1'b0;
    pronto             = 1'b0;
    erro               = 1'b0;

    unique case (estado)
      INICIAL: begin
        {zera_sensor_agua, zera_sensor_xicara, zera_bomba, zera_valvula, zera_ebulidor, zera_serial} = '1;
        tentativas_nxt = '0;
        esperas_nxt    = '0;
        gap_zera       = 1'b1;
`ifdef CAFETEIRA_RECHECA_XICARA_EN
        recheca_nxt    = 1'b0;
`endif
        estado_nxt     = ESPERA_PEDIDO;
      end
      ESPERA_PEDIDO: if (bus.pronto_serial) estado_nxt = MEDE_AGUA;
      MEDE_AGUA: begin
        medir_agua = 1'b1;
        estado_nxt = ESPERA_AGUA;
      end
      ESPERA_AGUA: begin
        if (bus.pronto_sensor_agua) estado_nxt = CHECA_AGUA;
        else if (bus.timeout_agua) begin
          if (tentativas < TENT_LIM) begin
            tentativas_nxt = tentativas + 1'b1;
            estado_nxt     = ZERA_AGUA;
          end else begin
            codigo_nxt = ERR_TIMEOUT_AGUA;
            estado_nxt = ERRO;
          end
        end
      end
      ZERA_AGUA: begin
        zera_sensor_agua = 1'b1;
        estado_nxt       = MEDE_AGUA;
      end
      CHECA_AGUA: begin
        if (bus.suficiente) begin
          tentativas_nxt = '0;
          estado_nxt     = MEDE_XICARA;
        end else begin
          codigo_nxt = ERR_SEM_AGUA;
          estado_nxt = ERRO;
        end
      end
      MEDE_XICARA: begin
        verifica_xicara = 1'b1;
        estado_nxt      = ESPERA_XICARA;
      end
      ESPERA_XICARA: begin
        if (bus.pronto_sensor_xicara) estado_nxt = CHECA_XICARA;
        else if (bus.timeout_xicara) begin
          if (tentativas < TENT_LIM) begin
            tentativas_nxt = tentativas + 1'b1;
            estado_nxt     = ZERA_XICARA;
          end else begin
            codigo_nxt = ERR_TIMEOUT_XICARA;
            estado_nxt = ERRO;
          end
        end
      end
      ZERA_XICARA: begin
        zera_sensor_xicara = 1'b1;
        estado_nxt         = MEDE_XICARA;
      end
      CHECA_XICARA: begin
`ifdef CAFETEIRA_RECHECA_XICARA_EN
        // A missing cup after heating means it was removed: no gap retries then.
        if (bus.tem_xicara) estado_nxt = recheca ? VALVULA : BOMBA;
        else if (recheca) begin
          codigo_nxt = ERR_XICARA_REMOVIDA;
          estado_nxt = ERRO;
        end
`else
        if (bus.tem_xicara) estado_nxt = BOMBA;
`endif
        else if (esperas < ESP_LIM) begin
          esperas_nxt = esperas + 1'b1;
          estado_nxt  = ESPERA_GAP;
        end else begin
          codigo_nxt = ERR_SEM_XICARA;
          estado_nxt = ERRO;
        end
      end
      ESPERA_GAP: begin
        gap_conta = 1'b1;
        if (gap_fim) estado_nxt = ZERA_XICARA;
      end
      BOMBA: begin
        liga_bomba = 1'b1;
        if (bus.fim_bomba) estado_nxt = EBULIDOR;
      end
      EBULIDOR: begin
        liga_ebulidor = 1'b1;
        if (bus.fim_ebulidor) begin
`ifdef CAFETEIRA_RECHECA_XICARA_EN
          recheca_nxt    = 1'b1;
          tentativas_nxt = '0;
          estado_nxt     = MEDE_XICARA;
`else
          estado_nxt     = VALVULA;
`endif
        end else if (bus.timeout_ebulidor) begin
          codigo_nxt = ERR_TIMEOUT_EBULIDOR;
          estado_nxt = ERRO;
        end
      end
      VALVULA: begin
        liga_valvula = 1'b1;
        if (bus.fim_valvula) estado_nxt = FIM;
      end
      FIM: begin
        pronto     = 1'b1;
        estado_nxt = INICIAL;
      end
      ERRO: begin
        erro = 1'b1;
        if (bus.reconhece) begin
          codigo_nxt = ERR_NENHUM;
          estado_nxt = INICIAL;
        end
      end
      default: estado_nxt = INICIAL;
    endcase
  end

  assign bus.zera_sensor_agua   = zera_sensor_agua;
  assign bus.zera_sensor_xicara = zera_sensor_xicara;
  assign bus.zera_bomba         = zera_bomba;
  assign bus.zera_valvula       = zera_valvula;
  assign bus.zera_ebulidor      = zera_ebulidor;
  assign bus.zera_serial        = zera_serial;
  assign bus.medir_agua         = medir_agua;
  assign bus.verifica_xicara    = verifica_xicara;
  assign bus.liga_bomba         = liga_bomba;
  assign bus.liga_ebulidor      = liga_ebulidor;
  assign bus.liga_valvula       = liga_valvula;
  assign bus.pronto             = pronto;
  assign bus.erro               = erro;
  assign bus.codigo_erro        = codigo;
  assign bus.db_estado          = estado;
endmodule

// File: tb/tb_cafeteira_uc.sv
// Scoreboard bench for cafeteira_uc: expected state/error-code pairs are queued as stimulus is driven.
module tb_cafeteira_uc;
  import cafeteira_pkg::*;

  localparam int unsigned GAP = 4;
  localparam logic [9:0] PS  = 10'd1,   PSA = 10'd2,   TA = 10'd4,   PSX = 10'd8,  TX  = 10'd16;
  localparam logic [9:0] FB  = 10'd32,  FE  = 10'd64,  TE = 10'd128, FV  = 10'd256, REC = 10'd512;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cafeteira_uc_if bus();

  cafeteira_uc #(
    .MAX_TENTATIVAS    (3),
    .MAX_ESPERA_XICARA (10),
    .GAP_CICLOS        (GAP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] estado;
    logic [2:0] codigo;
  } esperado_t;

  esperado_t   sb_q[$];
  esperado_t   sb_e;
  int unsigned n_chk = 0, n_pass = 0, n_pronto = 0, n_liga = 0, dwell = 0;
  logic [3:0]  est_prev = 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    if (obs === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, req, $time);
  endtask

  task automatic esp(input estado_t s, input logic [2:0] c);
    esperado_t x;
    x.estado = s;
    x.codigo = c;
    sb_q.push_back(x);
  endtask

  task automatic pulso(input logic [9:0] m);
    @(negedge clock);
    {bus.reconhece, bus.fim_valvula, bus.timeout_ebulidor, bus.fim_ebulidor, bus.fim_bomba,
     bus.timeout_xicara, bus.pronto_sensor_xicara, bus.timeout_agua, bus.pronto_sensor_agua,
     bus.pronto_serial} = m;
    @(negedge clock);
    {bus.reconhece, bus.fim_valvula, bus.timeout_ebulidor, bus.fim_ebulidor, bus.fim_bomba,
     bus.timeout_xicara, bus.pronto_sensor_xicara, bus.timeout_agua, bus.pronto_sensor_agua,
     bus.pronto_serial} = '0;
  endtask

  task automatic espera_estado(input estado_t s, input string tag);
    int unsigned n = 0;
    while (bus.db_estado != s && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk(tag, {28'd0, bus.db_estado}, {28'd0, s});
  endtask

  // Scoreboard monitor: every state change consumes one queued expectation.
  always @(negedge clock) begin
    if (bus.pronto) n_pronto++;
    if (bus.liga_bomba | bus.liga_ebulidor | bus.liga_valvula) n_liga++;
    if (bus.db_estado != est_prev) begin
      if (est_prev == ESPERA_GAP) chk("gap_ciclos", dwell, GAP);
      if (sb_q.size() == 0) chk("sb_inesperado", sb_q.size(), 1);
      else begin
        sb_e = sb_q.pop_front();
        chk("sb_estado", {28'd0, bus.db_estado}, {28'd0, sb_e.estado});
        chk("sb_codigo", {29'd0, bus.codigo_erro}, {29'd0, sb_e.codigo});
      end
      est_prev = bus.db_estado;
      dwell    = 1;
    end else dwell++;
  end

  task automatic pedido_agua_ok();
    esp(MEDE_AGUA, ERR_NENHUM); esp(ESPERA_AGUA, ERR_NENHUM);
    pulso(PS);
    chk("medir_agua", bus.medir_agua, 1);
    esp(CHECA_AGUA, ERR_NENHUM); esp(MEDE_XICARA, ERR_NENHUM); esp(ESPERA_XICARA, ERR_NENHUM);
    bus.suficiente = 1'b1;
    repeat (2) @(negedge clock);
    pulso(PSA);
    @(negedge clock);
    chk("verifica_xicara", bus.verifica_xicara, 1);
    espera_estado(ESPERA_XICARA, "espera_xicara");
  endtask

  task automatic ate_bomba();
    bus.tem_xicara = 1'b1;
    esp(CHECA_XICARA, ERR_NENHUM); esp(BOMBA, ERR_NENHUM);
    pulso(PSX);
    espera_estado(BOMBA, "bomba");
  endtask

  task automatic fim_preparo(input logic [9:0] m_ebul);
    chk("liga_bomba", bus.liga_bomba, 1);
    esp(EBULIDOR, ERR_NENHUM);
    repeat (4) @(negedge clock);
    pulso(FB);
    chk("liga_ebulidor", bus.liga_ebulidor, 1);
`ifdef CAFETEIRA_RECHECA_XICARA_EN
    esp(MEDE_XICARA, ERR_NENHUM); esp(ESPERA_XICARA, ERR_NENHUM);
    repeat (4) @(negedge clock);
    pulso(m_ebul);
    bus.tem_xicara = 1'b1;
    esp(CHECA_XICARA, ERR_NENHUM); esp(VALVULA, ERR_NENHUM);
    pulso(PSX);
    espera_estado(VALVULA, "valvula");
`else
    esp(VALVULA, ERR_NENHUM);
    repeat (4) @(negedge clock);
    pulso(m_ebul);
`endif
    chk("liga_valvula", bus.liga_valvula, 1);
    esp(FIM, ERR_NENHUM); esp(INICIAL, ERR_NENHUM); esp(ESPERA_PEDIDO, ERR_NENHUM);
    n_pronto = 0;
    repeat (4) @(negedge clock);
    pulso(FV);
    espera_estado(ESPERA_PEDIDO, "volta_pedido");
    chk("pronto_largura", n_pronto, 1);
  endtask

  task automatic reconhecer();
    chk("erro_alto", bus.erro, 1);
    chk("liga_em_erro", {bus.liga_bomba, bus.liga_ebulidor, bus.liga_valvula}, 0);
    esp(INICIAL, ERR_NENHUM); esp(ESPERA_PEDIDO, ERR_NENHUM);
    pulso(REC);
    chk("codigo_limpo", bus.codigo_erro, ERR_NENHUM);
    espera_estado(ESPERA_PEDIDO, "pos_reconhece");
  endtask

  task automatic gap_zero();
    bus.tem_xicara = 1'b0;
    esp(CHECA_XICARA, ERR_NENHUM); esp(ESPERA_GAP, ERR_NENHUM); esp(ZERA_XICARA, ERR_NENHUM);
    esp(MEDE_XICARA, ERR_NENHUM); esp(ESPERA_XICARA, ERR_NENHUM);
    pulso(PSX);
    espera_estado(ESPERA_XICARA, "gap_volta");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    {bus.reconhece, bus.fim_valvula, bus.timeout_ebulidor, bus.fim_ebulidor, bus.fim_bomba,
     bus.timeout_xicara, bus.pronto_sensor_xicara, bus.timeout_agua, bus.pronto_sensor_agua,
     bus.pronto_serial} = '0;
    bus.suficiente = 1'b0;
    bus.tem_xicara = 1'b0;

    // reset state
    @(negedge clock);
    chk("rst_estado", bus.db_estado, INICIAL);
    chk("rst_zera", {bus.zera_sensor_agua, bus.zera_sensor_xicara, bus.zera_bomba,
                     bus.zera_valvula, bus.zera_ebulidor, bus.zera_serial}, 6'h3F);
    chk("rst_saidas", {bus.medir_agua, bus.verifica_xicara, bus.liga_bomba, bus.liga_ebulidor,
                       bus.liga_valvula, bus.pronto, bus.erro}, 0);
    chk("rst_codigo", bus.codigo_erro, 0);
    @(negedge clock);
    #2;
    esp(ESPERA_PEDIDO, ERR_NENHUM);
    reset = 1'b1;
    espera_estado(ESPERA_PEDIDO, "pos_reset");

    // 1: happy path; reconhece must be ignored while idle
    pulso(REC);
    pedido_agua_ok();
    ate_bomba();
    fim_preparo(FE);

    // 2: water sensor timeouts exhaust retries
    esp(MEDE_AGUA, ERR_NENHUM); esp(ESPERA_AGUA, ERR_NENHUM);
    pulso(PS);
    espera_estado(ESPERA_AGUA, "espera_agua");
    for (int i = 0; i < 2; i++) begin
      esp(ZERA_AGUA, ERR_NENHUM); esp(MEDE_AGUA, ERR_NENHUM); esp(ESPERA_AGUA, ERR_NENHUM);
      pulso(TA);
      chk("zera_sensor_agua", bus.zera_sensor_agua, 1);
      espera_estado(ESPERA_AGUA, "retry_agua");
    end
    esp(ERRO, ERR_TIMEOUT_AGUA);
    pulso(TA);
    chk("codigo_timeout_agua", bus.codigo_erro, ERR_TIMEOUT_AGUA);
    reconhecer();

    // 3: cup sensor retry, two empty readings with gaps, then cup found
    pedido_agua_ok();
    esp(ZERA_XICARA, ERR_NENHUM); esp(MEDE_XICARA, ERR_NENHUM); esp(ESPERA_XICARA, ERR_NENHUM);
    pulso(TX);
    chk("zera_sensor_xicara", bus.zera_sensor_xicara, 1);
    espera_estado(ESPERA_XICARA, "retry_xicara");
    for (int i = 0; i < 2; i++) gap_zero();
    ate_bomba();
    fim_preparo(FE);

    // 3b: ten empty readings
    pedido_agua_ok();
    for (int i = 0; i < 9; i++) gap_zero();
    bus.tem_xicara = 1'b0;
    esp(CHECA_XICARA, ERR_NENHUM); esp(ERRO, ERR_SEM_XICARA);
    pulso(PSX);
    espera_estado(ERRO, "erro_sem_xicara");
    reconhecer();

    // 4: insufficient water; pronto wins over simultaneous timeout
    n_liga = 0;
    bus.suficiente = 1'b0;
    esp(MEDE_AGUA, ERR_NENHUM); esp(ESPERA_AGUA, ERR_NENHUM);
    pulso(PS);
    espera_estado(ESPERA_AGUA, "espera_agua2");
    esp(CHECA_AGUA, ERR_NENHUM); esp(ERRO, ERR_SEM_AGUA);
    pulso(PSA | TA);
    espera_estado(ERRO, "erro_sem_agua");
    chk("liga_nunca", n_liga, 0);
    reconhecer();

    // 5: asynchronous reset mid-pump
    pedido_agua_ok();
    ate_bomba();
    repeat (2) @(negedge clock);
    esp(INICIAL, ERR_NENHUM);
    #2 reset = 1'b0;
    #1;
    chk("rst_liga_bomba", bus.liga_bomba, 0);
    chk("rst_zera_mid", {bus.zera_sensor_agua, bus.zera_sensor_xicara, bus.zera_bomba,
                         bus.zera_valvula, bus.zera_ebulidor, bus.zera_serial}, 6'h3F);
    chk("rst_estado_mid", bus.db_estado, INICIAL);
    @(negedge clock);
    #2;
    esp(ESPERA_PEDIDO, ERR_NENHUM);
    reset = 1'b1;
    espera_estado(ESPERA_PEDIDO, "pos_reset_mid");

    // 6: fim_ebulidor beats simultaneous timeout; timeout alone is an error
    pedido_agua_ok();
    ate_bomba();
    fim_preparo(FE | TE);
    pedido_agua_ok();
    ate_bomba();
    esp(EBULIDOR, ERR_NENHUM);
    pulso(FB);
    esp(ERRO, ERR_TIMEOUT_EBULIDOR);
    repeat (3) @(negedge clock);
    pulso(TE);
    reconhecer();
`ifdef CAFETEIRA_RECHECA_XICARA_EN
    pedido_agua_ok();
    ate_bomba();
    esp(EBULIDOR, ERR_NENHUM);
    pulso(FB);
    esp(MEDE_XICARA, ERR_NENHUM); esp(ESPERA_XICARA, ERR_NENHUM);
    pulso(FE);
    bus.tem_xicara = 1'b0;
    esp(CHECA_XICARA, ERR_NENHUM); esp(ERRO, ERR_XICARA_REMOVIDA);
    pulso(PSX);
    espera_estado(ERRO, "erro_xicara_removida");
    reconhecer();
`endif

    repeat (3) @(negedge clock);
    chk("sb_vazio", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
